// File: rtl/phased_table_ctrl_if.sv
// Request/response bus between placement units and the placement table controller.
interface phased_table_ctrl_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              wr_req_valid;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [DATA_W-1:0] wr_req_data;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_rsp_valid;
    logic [ADDR_W-1:0] rd_rsp_addr;
    logic [DATA_W-1:0] rd_rsp_data;

    // Placement unit side: issues requests, receives responses.
    modport master (
        output wr_req_valid, wr_req_addr, wr_req_data, rd_req_valid, rd_req_addr,
        input  wr_req_ready, rd_req_ready, rd_rsp_valid, rd_rsp_addr, rd_rsp_data
    );

    // Table controller side.
    modport slave (
        input  wr_req_valid, wr_req_addr, wr_req_data, rd_req_valid, rd_req_addr,
        output wr_req_ready, rd_req_ready, rd_rsp_valid, rd_rsp_addr, rd_rsp_data
    );
endinterface

// File: rtl/phased_table_ctrl.sv
// Placement table controller: buffers write/read requests in two FIFOs and
// services them on the write/read phase strobes of the 4-cycle frame.
module phased_table_ctrl #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write_en,
    input  logic               read_en,
    phased_table_ctrl_if.slave bus,
    output logic               busy
);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned TBL_SIZE = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // Write request FIFO
    logic [ADDR_W-1:0] wr_addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] wr_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_head_q, wr_tail_q;
    logic [CNT_W-1:0]  wr_count_q;

    // Read request FIFO
    logic [ADDR_W-1:0] rd_addr_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_head_q, rd_tail_q;
    logic [CNT_W-1:0]  rd_count_q;

    logic [DATA_W-1:0] tbl_q [TBL_SIZE];

    logic              rsp_valid_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic              wr_push, wr_pop, rd_push, rd_pop;
    logic [ADDR_W-1:0] rd_head_addr;

    // Ready comes from the pre-pop count, so a full FIFO never accepts in a pop cycle.
    assign bus.wr_req_ready = (wr_count_q != FULL_CNT);
    assign bus.rd_req_ready = (rd_count_q != FULL_CNT);

    assign wr_push = bus.wr_req_valid && bus.wr_req_ready;
    assign rd_push = bus.rd_req_valid && bus.rd_req_ready;
    assign wr_pop  = write_en && (wr_count_q != '0);
    assign rd_pop  = read_en && (rd_count_q != '0);

    assign rd_head_addr = rd_addr_mem[rd_head_q];

    assign bus.rd_rsp_valid = rsp_valid_q;
    assign bus.rd_rsp_addr  = rsp_addr_q;
    assign bus.rd_rsp_data  = rsp_data_q;

    assign busy = (wr_count_q != '0) || (rd_count_q != '0) || rsp_valid_q;

    // FIFO payload storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (wr_push) begin
            wr_addr_mem[wr_tail_q] <= bus.wr_req_addr;
            wr_data_mem[wr_tail_q] <= bus.wr_req_data;
        end
        if (rd_push) begin
            rd_addr_mem[rd_tail_q] <= bus.rd_req_addr;
        end
    end

    // Write FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_head_q  <= '0;
            wr_tail_q  <= '0;
            wr_count_q <= '0;
        end else begin
            if (wr_push) wr_tail_q <= wr_tail_q + PTR_W'(1);
            if (wr_pop)  wr_head_q <= wr_head_q + PTR_W'(1);
            if (wr_push && !wr_pop)      wr_count_q <= wr_count_q + CNT_W'(1);
            else if (!wr_push && wr_pop) wr_count_q <= wr_count_q - CNT_W'(1);
        end
    end

    // Read FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_head_q  <= '0;
            rd_tail_q  <= '0;
            rd_count_q <= '0;
        end else begin
            if (rd_push) rd_tail_q <= rd_tail_q + PTR_W'(1);
            if (rd_pop)  rd_head_q <= rd_head_q + PTR_W'(1);
            if (rd_push && !rd_pop)      rd_count_q <= rd_count_q + CNT_W'(1);
            else if (!rd_push && rd_pop) rd_count_q <= rd_count_q - CNT_W'(1);
        end
    end

    // Table commit: one write per write-phase strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TBL_SIZE; i++) tbl_q[i] <= '0;
        end else if (wr_pop) begin
            tbl_q[wr_addr_mem[wr_head_q]] <= wr_data_mem[wr_head_q];
        end
    end

    // Read response: samples the table before any same-edge write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rd_pop;
            if (rd_pop) begin
                rsp_addr_q <= rd_head_addr;
                rsp_data_q <= tbl_q[rd_head_addr];
            end
        end
    end
endmodule

// File: tb/tb_phased_table_ctrl.sv
// Directed bench for phased_table_ctrl: one task per scenario, inline checks.
module tb_phased_table_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic write_en;
    logic read_en;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    phased_table_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    phased_table_ctrl #(.ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .write_en (write_en),
        .read_en  (read_en),
        .bus      (bus),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then step to 1 time unit after the next rising edge.
    task automatic cyc(input logic we, input logic re, input logic wv, input logic [3:0] wa,
                       input logic [7:0] wd, input logic rv, input logic [3:0] ra);
        write_en         = we;
        read_en          = re;
        bus.wr_req_valid = wv;
        bus.wr_req_addr  = wa;
        bus.wr_req_data  = wd;
        bus.rd_req_valid = rv;
        bus.rd_req_addr  = ra;
        @(posedge clk);
        #1;
    endtask

    // Push one read and strobe it; returns the response outputs one cycle later.
    task automatic do_read(input logic [3:0] a, output logic v, output logic [3:0] ra,
                           output logic [7:0] d);
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, a);
        cyc(1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        v  = bus.rd_rsp_valid;
        ra = bus.rd_rsp_addr;
        d  = bus.rd_rsp_data;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        write_en = 1'b0; read_en = 1'b0;
        bus.wr_req_valid = 1'b0; bus.wr_req_addr = '0; bus.wr_req_data = '0;
        bus.rd_req_valid = 1'b0; bus.rd_req_addr = '0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (bus.rd_rsp_valid !== 1'b0) begin errors++;
            $display("FAIL reset_rsp_valid: got %b expected 0", bus.rd_rsp_valid); end
        checks++; if (bus.rd_rsp_addr !== 4'h0) begin errors++;
            $display("FAIL reset_rsp_addr: got %h expected 0", bus.rd_rsp_addr); end
        checks++; if (bus.rd_rsp_data !== 8'h00) begin errors++;
            $display("FAIL reset_rsp_data: got %h expected 00", bus.rd_rsp_data); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (bus.wr_req_ready !== 1'b1 || bus.rd_req_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready: got wr=%b rd=%b expected 1 1",
                     bus.wr_req_ready, bus.rd_req_ready); end
        rst = 1'b0;
    endtask

    task automatic test_frame;
        cyc(1'b0, 1'b0, 1'b1, 4'h3, 8'hA5, 1'b0, 4'h0);   // cycle 0: push write
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL frame_busy: got %b expected 1", busy); end
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'h3);   // cycle 1: push read
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);   // cycle 2: write commit
        checks++; if (bus.rd_rsp_valid !== 1'b0) begin errors++;
            $display("FAIL frame_no_early_rsp: got %b expected 0", bus.rd_rsp_valid); end
        cyc(1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);   // cycle 3: read service
        checks++; if (bus.rd_rsp_valid !== 1'b1 || bus.rd_rsp_addr !== 4'h3 ||
                      bus.rd_rsp_data !== 8'hA5) begin errors++;
            $display("FAIL frame_rsp: got v=%b a=%h d=%h expected v=1 a=3 d=a5",
                     bus.rd_rsp_valid, bus.rd_rsp_addr, bus.rd_rsp_data); end
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        checks++; if (bus.rd_rsp_valid !== 1'b0 || bus.rd_rsp_data !== 8'hA5) begin errors++;
            $display("FAIL frame_pulse_end: got v=%b d=%h expected v=0 d=a5",
                     bus.rd_rsp_valid, bus.rd_rsp_data); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL frame_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] wa [5] = '{4'h8, 4'h9, 4'hA, 4'h8, 4'h9};
        logic [7:0] wd [5] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        logic       v;
        logic [3:0] ra;
        logic [7:0] d;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, wa[i], wd[i], 1'b0, 4'h0);
        checks++; if (bus.wr_req_ready !== 1'b0) begin errors++;
            $display("FAIL b2b_full: got ready=%b expected 0", bus.wr_req_ready); end
        cyc(1'b0, 1'b0, 1'b1, wa[4], wd[4], 1'b0, 4'h0);  // 5th held
        checks++; if (bus.wr_req_ready !== 1'b0) begin errors++;
            $display("FAIL b2b_held: got ready=%b expected 0", bus.wr_req_ready); end
        cyc(1'b1, 1'b0, 1'b1, wa[4], wd[4], 1'b0, 4'h0);  // pop, no push
        checks++; if (bus.wr_req_ready !== 1'b1) begin errors++;
            $display("FAIL b2b_after_pop: got ready=%b expected 1", bus.wr_req_ready); end
        cyc(1'b0, 1'b0, 1'b1, wa[4], wd[4], 1'b0, 4'h0);  // 5th accepted
        checks++; if (bus.wr_req_ready !== 1'b0) begin errors++;
            $display("FAIL b2b_fifth_accepted: got ready=%b expected 0", bus.wr_req_ready); end
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL b2b_drained: got busy=%b expected 0", busy); end
        // Later writes to 8 and 9 must win if commits happened in order.
        do_read(4'h8, v, ra, d);
        checks++; if (v !== 1'b1 || ra !== 4'h8 || d !== 8'h34) begin errors++;
            $display("FAIL b2b_addr8: got v=%b a=%h d=%h expected v=1 a=8 d=34", v, ra, d); end
        do_read(4'h9, v, ra, d);
        checks++; if (v !== 1'b1 || d !== 8'h35) begin errors++;
            $display("FAIL b2b_addr9: got v=%b d=%h expected v=1 d=35", v, d); end
        do_read(4'hA, v, ra, d);
        checks++; if (v !== 1'b1 || d !== 8'h33) begin errors++;
            $display("FAIL b2b_addr10: got v=%b d=%h expected v=1 d=33", v, d); end
    endtask

    task automatic test_unwritten_and_overwrite;
        logic       v;
        logic [3:0] ra;
        logic [7:0] d;
        do_read(4'h7, v, ra, d);
        checks++; if (v !== 1'b1 || ra !== 4'h7 || d !== 8'h00) begin errors++;
            $display("FAIL unwritten: got v=%b a=%h d=%h expected v=1 a=7 d=00", v, ra, d); end
        cyc(1'b0, 1'b0, 1'b1, 4'h2, 8'h11, 1'b0, 4'h0);
        cyc(1'b0, 1'b0, 1'b1, 4'h2, 8'h22, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        do_read(4'h2, v, ra, d);
        checks++; if (v !== 1'b1 || d !== 8'h22) begin errors++;
            $display("FAIL overwrite: got v=%b d=%h expected v=1 d=22", v, d); end
    endtask

    task automatic test_idle_strobes;
        logic       v;
        logic [3:0] ra;
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            cyc((i % 4) == 2, (i % 4) == 3, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
            checks++; if (bus.rd_rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
                $display("FAIL idle_cycle%0d: got v=%b busy=%b expected 0 0",
                         i, bus.rd_rsp_valid, busy); end
        end
        do_read(4'h2, v, ra, d);
        checks++; if (v !== 1'b1 || d !== 8'h22) begin errors++;
            $display("FAIL idle_table: got v=%b d=%h expected v=1 d=22", v, d); end
    endtask

    task automatic test_both_strobes;
        logic       v;
        logic [3:0] ra;
        logic [7:0] d;
        cyc(1'b0, 1'b0, 1'b1, 4'h5, 8'h10, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        cyc(1'b0, 1'b0, 1'b1, 4'h5, 8'h20, 1'b1, 4'h5);
        cyc(1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        checks++; if (bus.rd_rsp_valid !== 1'b1 || bus.rd_rsp_data !== 8'h10) begin errors++;
            $display("FAIL both_pre_write: got v=%b d=%h expected v=1 d=10",
                     bus.rd_rsp_valid, bus.rd_rsp_data); end
        do_read(4'h5, v, ra, d);
        checks++; if (v !== 1'b1 || d !== 8'h20) begin errors++;
            $display("FAIL both_post_write: got v=%b d=%h expected v=1 d=20", v, d); end
    endtask

    task automatic test_reset_mid_op;
        logic       v;
        logic [3:0] ra;
        logic [7:0] d;
        cyc(1'b0, 1'b0, 1'b1, 4'h2, 8'hAA, 1'b1, 4'h9);
        cyc(1'b0, 1'b0, 1'b1, 4'h3, 8'hBB, 1'b0, 4'h0);
        cyc(1'b0, 1'b0, 1'b1, 4'h4, 8'hCC, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        checks++; if (bus.rd_rsp_valid !== 1'b1 || busy !== 1'b1) begin errors++;
            $display("FAIL midrst_pending: got v=%b busy=%b expected 1 1",
                     bus.rd_rsp_valid, busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.rd_rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL midrst_cancel: got v=%b busy=%b expected 0 0",
                     bus.rd_rsp_valid, busy); end
        checks++; if (bus.wr_req_ready !== 1'b1 || bus.rd_req_ready !== 1'b1) begin errors++;
            $display("FAIL midrst_ready: got wr=%b rd=%b expected 1 1",
                     bus.wr_req_ready, bus.rd_req_ready); end
        #2 rst = 1'b0;
        do_read(4'h9, v, ra, d);
        checks++; if (v !== 1'b1 || d !== 8'h00) begin errors++;
            $display("FAIL midrst_addr9: got v=%b d=%h expected v=1 d=00", v, d); end
        do_read(4'h5, v, ra, d);
        checks++; if (v !== 1'b1 || d !== 8'h00) begin errors++;
            $display("FAIL midrst_addr5: got v=%b d=%h expected v=1 d=00", v, d); end
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL midrst_queue_dropped: got busy=%b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_unwritten_and_overwrite();
        test_idle_strobes();
        test_both_strobes();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
